// File: rtl/bit_unstuff_monitor.sv
// Receive-side bit-unstuffing monitor: flags the stuffed bit after RUN_LEN ones and checks it is 0.
// Define BIT_UNSTUFF_STATS_EN to add the per-packet stuffed-bit counter on stuff_count.
module bit_unstuff_monitor #(
  parameter int RUN_LEN = 6,
  parameter int STAT_W  = 8,
  localparam int CW     = $clog2(RUN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_orig,
  input  logic              shift_enable,
  input  logic              packet_active,
  output logic              invalid_bit,
  output logic              stuff_error,
  output logic              err_flag,
  output logic [CW-1:0]     run_count,
  output logic [STAT_W-1:0] stuff_count
);

  typedef enum logic [1:0] {IDLE, RUN, STUFF, ERR} state_t;

  localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(RUN_LEN);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state, state_n;
  logic          invalid_n, stuff_error_n, err_flag_n;
  logic [CW-1:0] run_count_n;
  logic          start_pkt, stuff_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      invalid_bit <= 1'b0;
      stuff_error <= 1'b0;
      err_flag    <= 1'b0;
      run_count   <= '0;
    end else begin
      state       <= state_n;
      invalid_bit <= invalid_n;
      stuff_error <= stuff_error_n;
      err_flag    <= err_flag_n;
      run_count   <= run_count_n;
    end
  end

  // Leaving IDLE handles a same-cycle strobe as an ordinary RUN bit; RUN_LEN >= 2 means it cannot complete a run.
  always_comb begin
    state_n       = state;
    invalid_n     = invalid_bit;
    stuff_error_n = 1'b0;
    err_flag_n    = err_flag;
    run_count_n   = run_count;
    start_pkt     = 1'b0;
    stuff_ok      = 1'b0;
    if (!packet_active) begin
      state_n     = IDLE;
      invalid_n   = 1'b0;
      err_flag_n  = 1'b0;
      run_count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          start_pkt   = 1'b1;
          state_n     = RUN;
          run_count_n = (shift_enable && d_orig) ? ONE : '0;
        end
        RUN: begin
          if (shift_enable) begin
            if (!d_orig) begin
              run_count_n = '0;
            end else if (run_count == LAST) begin
              run_count_n = FULL;
              state_n     = STUFF;
              invalid_n   = 1'b1;
            end else begin
              run_count_n = run_count + ONE;
            end
          end
        end
        STUFF: begin
          if (shift_enable) begin
            invalid_n = 1'b0;
            if (!d_orig) begin
              run_count_n = '0;
              state_n     = RUN;
              stuff_ok    = 1'b1;
            end else begin
              state_n       = ERR;
              stuff_error_n = 1'b1;
              err_flag_n    = 1'b1;
            end
          end
        end
        ERR: begin
          state_n = ERR;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

`ifdef BIT_UNSTUFF_STATS_EN
  // Saturating per-packet count; holds through ERR and IDLE until the next packet starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuff_count <= '0;
    end else if (start_pkt) begin
      stuff_count <= '0;
    end else if (stuff_ok && (stuff_count != '1)) begin
      stuff_count <= stuff_count + 1'b1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = start_pkt ^ stuff_ok;
  assign stuff_count  = '0;
`endif

endmodule

// File: tb/tb_bit_unstuff_monitor.sv
// Bench for bit_unstuff_monitor: RUN_LEN=6 and RUN_LEN=3 instances share stimulus and are checked
// every cycle against a rule-level model, plus directed literal expectations.
module tb_bit_unstuff_monitor;

  logic clk = 1'b0;
  logic rst;
  logic d_orig, shift_enable, packet_active;

  logic       aInv, aSerr, aEflag;
  logic [2:0] aRun;
  logic [7:0] aStuff;
  logic       bInv, bSerr, bEflag;
  logic [1:0] bRun;
  logic [7:0] bStuff;

  int checks = 0;
  int errors = 0;
  int invRises = 0;
  logic aInvPrev = 1'b0;

  always #5 clk = ~clk;

  bit_unstuff_monitor #(.RUN_LEN(6), .STAT_W(8)) dutA (
    .clk(clk), .rst(rst), .d_orig(d_orig), .shift_enable(shift_enable),
    .packet_active(packet_active), .invalid_bit(aInv), .stuff_error(aSerr),
    .err_flag(aEflag), .run_count(aRun), .stuff_count(aStuff)
  );

  bit_unstuff_monitor #(.RUN_LEN(3), .STAT_W(8)) dutB (
    .clk(clk), .rst(rst), .d_orig(d_orig), .shift_enable(shift_enable),
    .packet_active(packet_active), .invalid_bit(bInv), .stuff_error(bSerr),
    .err_flag(bEflag), .run_count(bRun), .stuff_count(bStuff)
  );

  // Rule-level model: per instance, count consecutive ones and remember whether a stuffed bit is owed.
  int runLenTab[2] = '{6, 3};
  int mOnes[2];
  int mStuffs[2];
  bit mActive[2], mOwed[2], mDead[2], mInv[2], mSerr[2], mEflag[2];

  task automatic modelStep(input int k);
    mSerr[k] = 1'b0;
    if (!packet_active) begin
      mActive[k] = 1'b0; mOwed[k] = 1'b0; mDead[k] = 1'b0;
      mOnes[k] = 0; mInv[k] = 1'b0; mEflag[k] = 1'b0;
    end else begin
      if (!mActive[k]) begin
        mActive[k] = 1'b1; mOnes[k] = 0; mStuffs[k] = 0;
      end
      if (shift_enable && !mDead[k]) begin
        if (mOwed[k]) begin
          mOwed[k] = 1'b0;
          mInv[k]  = 1'b0;
          if (d_orig == 1'b0) begin
            mOnes[k] = 0;
            if (mStuffs[k] < 255) mStuffs[k]++;
          end else begin
            mDead[k] = 1'b1; mSerr[k] = 1'b1; mEflag[k] = 1'b1;
          end
        end else if (d_orig == 1'b0) begin
          mOnes[k] = 0;
        end else begin
          mOnes[k]++;
          if (mOnes[k] == runLenTab[k]) begin
            mOwed[k] = 1'b1; mInv[k] = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mActive[k] = 1'b0; mOwed[k] = 1'b0; mDead[k] = 1'b0; mOnes[k] = 0;
        mStuffs[k] = 0; mInv[k] = 1'b0; mSerr[k] = 1'b0; mEflag[k] = 1'b0;
      end else begin
        modelStep(k);
      end
    end
  end

  function automatic int expStuff(input int k);
`ifdef BIT_UNSTUFF_STATS_EN
    return mStuffs[k];
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic pa, input logic se, input logic d);
    packet_active = pa;
    shift_enable  = se;
    d_orig        = d;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("A.invalid_bit", 32'(aInv), 32'(mInv[0]));
    checkOutput("A.stuff_error", 32'(aSerr), 32'(mSerr[0]));
    checkOutput("A.err_flag", 32'(aEflag), 32'(mEflag[0]));
    checkOutput("A.run_count", 32'(aRun), 32'(mOnes[0]));
    checkOutput("A.stuff_count", 32'(aStuff), 32'(expStuff(0)));
    checkOutput("B.invalid_bit", 32'(bInv), 32'(mInv[1]));
    checkOutput("B.stuff_error", 32'(bSerr), 32'(mSerr[1]));
    checkOutput("B.err_flag", 32'(bEflag), 32'(mEflag[1]));
    checkOutput("B.run_count", 32'(bRun), 32'(mOnes[1]));
    checkOutput("B.stuff_count", 32'(bStuff), 32'(expStuff(1)));
    if (aInv === 1'b1 && aInvPrev !== 1'b1) invRises++;
    aInvPrev = aInv;
  end

  initial begin
    int expStats;
    logic [12:0] pat;
`ifdef BIT_UNSTUFF_STATS_EN
    expStats = 1;
`else
    expStats = 0;
`endif
    rst = 1'b1; packet_active = 1'b0; shift_enable = 1'b0; d_orig = 1'b0;
    #3;
    checkOutput("reset.invalid_bit", 32'(aInv), 32'd0);
    checkOutput("reset.run_count", 32'(aRun), 32'd0);
    checkOutput("reset.err_flag", 32'(aEflag), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] six ones then a valid stuffed zero");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t1.invalid_bit", 32'(aInv), 32'd1);
    checkOutput("t1.run_count", 32'(aRun), 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t1.invalid_cleared", 32'(aInv), 32'd0);
    checkOutput("t1.run_restart", 32'(aRun), 32'd0);
    checkOutput("t1.stuff_count", 32'(aStuff), 32'(expStats));
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] stuff error and frozen run count");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t2.stuff_error", 32'(aSerr), 32'd1);
    checkOutput("t2.err_flag", 32'(aEflag), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2.stuff_error_pulse", 32'(aSerr), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'(i % 2));
    checkOutput("t2.run_frozen", 32'(aRun), 32'd6);
    checkOutput("t2.err_sticky", 32'(aEflag), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t2.err_cleared", 32'(aEflag), 32'd0);
    checkOutput("t2.run_cleared", 32'(aRun), 32'd0);

    $display("[TB] run of five is not stuffed, run of six is");
    invRises = 0;
    pat = 13'b0111111011111;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b1, pat[i]);
      if (i == 4) checkOutput("t3.no_stuff_after_five", 32'(aInv), 32'd0);
      if (i == 4) checkOutput("t3.run_five", 32'(aRun), 32'd5);
      if (i == 11) checkOutput("t3.stuff_after_six", 32'(aInv), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1);
    end
    checkOutput("t3.invalid_rises", 32'(invRises), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] eighteen ones with stuffed zeros, back to back");
    invRises = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4.invalid_rises", 32'(invRises), 32'd3);
    checkOutput("t4.stuff_count", 32'(aStuff), 32'(3 * expStats));
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] RUN_LEN=3 instance, packet drop with strobe");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5.B.invalid_bit", 32'(bInv), 32'd1);
    checkOutput("t5.B.run_count", 32'(bRun), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t5.B.invalid_cleared", 32'(bInv), 32'd0);
    checkOutput("t5.B.no_stuff_error", 32'(bSerr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset while in STUFF");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t6.invalid_before_reset", 32'(aInv), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6.invalid_bit", 32'(aInv), 32'd0);
    checkOutput("t6.run_count", 32'(aRun), 32'd0);
    checkOutput("t6.stuff_count", 32'(aStuff), 32'd0);
    checkOutput("t6.B.err_flag", 32'(bEflag), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t6.no_stuff_error", 32'(aSerr), 32'd0);
    checkOutput("t6.run_after_reset", 32'(aRun), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_unstuff_monitor.md
Name: bit_unstuff_monitor

Overview:
Parametrised successor to the receive-side bit-stuff detector. Tracks runs of consecutive 1s in the NRZI-decoded stream and flags the stuffed bit that follows a run of RUN_LEN. Checks that the stuffed bit is actually 0 and reports a stuff error if it is not. Sits between the NRZI decoder and the RX shift register; the RCU gates shifts with invalid_bit and aborts the packet on stuff_error.

Parameters:
RUN_LEN, 6, consecutive-1 run length after which the next bit is a stuffed bit; legal range 2..15
STAT_W, 8, width of the stuffed-bit statistics counter; only used with the optional feature
(localparam CW = $clog2(RUN_LEN+1), width of run_count)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
d_orig  input  1  decoded data bit, valid when shift_enable is high
shift_enable  input  1  one-cycle strobe per received bit
packet_active  input  1  high from end of SYNC to EOP; low forces IDLE
invalid_bit  output  1  registered; the bit sampled at the next shift_enable is a stuffed bit
stuff_error  output  1  registered one-cycle pulse; stuffed-bit position carried a 1
err_flag  output  1  sticky error, held until packet_active falls
run_count  output  CW  current consecutive-1 count
stuff_count  output  STAT_W  stuffed bits removed this packet (optional feature only)

Behaviour:
- Reset (rst high, async): state=IDLE; invalid_bit, stuff_error, err_flag = 0; run_count = 0; stuff_count = 0.
- States: IDLE, RUN, STUFF, ERR. The state register and all outputs are flopped. No combinational path runs from inputs to outputs.
- packet_active low has priority over all other inputs. Any state goes to IDLE on the next edge, with run_count=0, invalid_bit=0 and err_flag=0.
- IDLE: on the edge where packet_active=1, go to RUN with run_count=0. A shift_enable on that same cycle is processed as a RUN-state bit. stuff_count clears on IDLE->RUN.
- RUN, on each edge with shift_enable=1:
  - d_orig=0: run_count <= 0.
  - d_orig=1 and run_count < RUN_LEN-1: run_count increments.
  - d_orig=1 and run_count == RUN_LEN-1: run_count <= RUN_LEN, state becomes STUFF, invalid_bit <= 1 on the same edge.
- No shift_enable: all values hold.
- STUFF: invalid_bit stays high until the next shift_enable. On that edge:
  - d_orig=0 (valid stuff): run_count <= 0, state returns to RUN, invalid_bit <= 0, stuff_count increments (saturating at all-ones). The stuffed 0 counts as a transition, so a new run starts from 0.
  - d_orig=1 (error): state becomes ERR, stuff_error <= 1 for exactly one cycle, err_flag <= 1, invalid_bit <= 0, run_count frozen at RUN_LEN.
- ERR: shift_enable is ignored. Outputs hold (stuff_error returns to 0) until packet_active falls.
- Latency: invalid_bit rises 1 clk after the shift_enable edge that samples the RUN_LEN-th consecutive 1.
- Back-to-back shift_enable on consecutive clocks is legal; every strobe is processed.
- run_count never exceeds RUN_LEN.
- Reset mid-packet returns the block to IDLE immediately, regardless of state.

Optional Feature:
BIT_UNSTUFF_STATS_EN
- Defined: stuff_count is a STAT_W-bit saturating counter of valid stuffed bits per packet. It clears on IDLE->RUN and holds through ERR and IDLE until the next packet starts.
- Undefined: the counter logic is omitted and stuff_count is tied to 0.

Test Plan:
- Reset then packet_active=1, shift 6 ones (RUN_LEN=6) -> invalid_bit=1 one clk after 6th strobe, run_count=6; shift a 0 -> invalid_bit=0, run_count=0, stuff_count=1, stuff_error never asserts.
- Shift 6 ones then a 1 -> stuff_error high exactly 1 clk, err_flag=1; further 10 strobes leave run_count=6; packet_active=0 -> err_flag=0, state IDLE.
- Pattern 1,1,1,1,1,0,1,1,1,1,1,1,0 -> invalid_bit asserts only after the final run of 6 ones, never after the first run of 5.
- 18 consecutive 1s with a 0 inserted after every 6 ones, at back-to-back strobes -> invalid_bit pulses 3 times, stuff_count=3 (macro on) / 0 (macro off).
- RUN_LEN=3 instance: 1,1,1 -> invalid_bit=1; packet_active drops on the same cycle as the next shift_enable -> IDLE, no stuff_error, invalid_bit=0.
- rst asserted while in STUFF with invalid_bit=1 -> all outputs 0 asynchronously, no stuff_error after release.
